// File: rtl/ram_be_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM.
// Holds the clear/idle state enum, address-width and byte-parity helpers.
package ram_be_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  function automatic int calc_addr_w(input int depth, input int data_w);
    return $clog2(depth) + $clog2(data_w / 8);
  endfunction

  // Even parity: the stored bit makes the 9-bit total even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_be_clear_fsm.sv
// Post-reset clear sequencer: walks every word once, then opens the port.
// Ports: clk, rst, clr_we/clr_addr (clear write), state, ready, init_done.
module ram_be_clear_fsm
  import ram_be_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [CW-1:0] clr_addr,
  output state_t        state,
  output logic          ready,
  output logic          init_done
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic          r_ready;
  logic          r_init_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_cnt       <= w_ncnt;
      r_ready     <= (w_nstate == IDLE);
      r_init_done <= (w_nstate == IDLE);
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    clr_we   = 1'b0;
    unique case (r_state)
      INIT: begin
        clr_we = 1'b1;
        if (r_cnt == LAST) begin
          w_nstate = IDLE;
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        w_nstate = IDLE;
      end
      default: begin
        w_nstate = INIT;
      end
    endcase
  end

  assign clr_addr  = r_cnt;
  assign state     = r_state;
  assign ready     = r_ready;
  assign init_done = r_init_done;

endmodule

// File: rtl/ram_be_sp.sv
// Single-port byte-addressed RAM with per-byte strobes and registered response.
// Ports: clk, rst, valid/ready, wr_rd, addr, be, din, dout, resp_valid, err,
// init_done; par_err_lanes when RAM_BE_PARITY_EN is defined.
module ram_be_sp
  import ram_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES),
  localparam int ADDR_W = calc_addr_w(DEPTH, DATA_W),
  localparam int IW     = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTES-1:0]  be,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              resp_valid,
  output logic              err,
`ifdef RAM_BE_PARITY_EN
  output logic [BYTES-1:0]  par_err_lanes,
`endif
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [IW:0]       DEPTH_L  = (IW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_clr_we;
  logic [IW-1:0]     w_clr_addr;
  state_t            w_state;
  logic              w_ready;
  logic [IW-1:0]     w_idx;
  logic              w_mis;
  logic              w_oor;
  logic              w_bad;
  logic              w_acc;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_rdata;
  logic [BYTES-1:0]  w_par_mis;

  logic              r_resp_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;

  ram_be_clear_fsm #(
    .DEPTH(DEPTH)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .state    (w_state),
    .ready    (w_ready),
    .init_done(init_done)
  );

  assign w_idx   = addr[ADDR_W-1:OFF_W];
  assign w_mis   = |(addr & OFF_MASK);
  assign w_oor   = ({1'b0, w_idx} >= DEPTH_L);
  assign w_bad   = w_mis | w_oor;
  assign w_acc   = valid & w_ready & (w_state == IDLE);
  assign w_wr_ok = w_acc & wr_rd & ~w_bad;
  assign w_rd_ok = w_acc & ~wr_rd & ~w_bad;
  assign w_rdata = mem[w_idx];

`ifdef RAM_BE_PARITY_EN
  logic [BYTES-1:0] r_par [DEPTH];
  logic [BYTES-1:0] w_par_rd;
  logic [BYTES-1:0] r_par_lanes;

  assign w_par_rd = r_par[w_idx];

  for (genvar g = 0; g < BYTES; g++) begin : g_par
    assign w_par_mis[g] = w_rd_ok &
      (even_parity(w_rdata[8*g +: 8]) ^ w_par_rd[g]);
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) r_par[w_idx][i] <= even_parity(din[8*i +: 8]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_lanes <= '0;
    else     r_par_lanes <= w_par_mis;
  end

  assign par_err_lanes = r_par_lanes;
`else
  assign w_par_mis = '0;
`endif

  // Clear and request writes never coincide: INIT holds ready low.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[w_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_resp_valid <= w_acc;
      r_err        <= w_acc & (w_bad | (|w_par_mis));
      if (w_rd_ok) r_dout <= w_rdata;
    end
  end

  assign ready      = w_ready;
  assign resp_valid = r_resp_valid;
  assign err        = r_err;
  assign dout       = r_dout;

endmodule

// File: tb/tb_ram_be_sp.sv
// Scoreboard bench for ram_be_sp (DATA_W=32, DEPTH=200).
// Reference model is a plain word array plus held read data.
module tb_ram_be_sp;

  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int AW    = 10;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          valid = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [3:0]    be    = '0;
  logic [DW-1:0] din   = '0;
  logic          ready;
  logic [DW-1:0] dout;
  logic          resp_valid;
  logic          err;
  logic          init_done;
`ifdef RAM_BE_PARITY_EN
  logic [3:0]    par_err_lanes;
`endif

  ram_be_sp #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .wr_rd     (wr_rd),
    .addr      (addr),
    .be        (be),
    .din       (din),
    .ready     (ready),
    .dout      (dout),
    .resp_valid(resp_valid),
    .err       (err),
`ifdef RAM_BE_PARITY_EN
    .par_err_lanes(par_err_lanes),
`endif
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dout;
    logic [3:0]  lanes;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] mdout = '0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_resp: got resp_valid=1 expected 0");
      end else begin
        me = q.pop_front();
        chk("resp_err", 32'(err), 32'(me.err));
        chk("resp_dout", dout, me.dout);
`ifdef RAM_BE_PARITY_EN
        chk("resp_lanes", 32'(par_err_lanes), 32'(me.lanes));
`endif
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    exp_t e;
    int   w;
    logic bad;
    w   = int'(a) / 4;
    bad = (int'(a) % 4 != 0) || (w >= DEPTH);
    if (!bad) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
      end else begin
        mdout = mdl[w];
      end
    end
    e.err   = bad;
    e.dout  = mdout;
    e.lanes = '0;
    q.push_back(e);
    valid = 1'b1;
    wr_rd = wr;
    addr  = a;
    be    = b;
    din   = d;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 32'(n), 32'(DEPTH));
    chk({nm, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_ready0"}, 32'(ready), 32'd0);
    chk({nm, "_rv0"}, 32'(resp_valid), 32'd0);
    chk({nm, "_idone0"}, 32'(init_done), 32'd0);
    chk({nm, "_dout0"}, dout, 32'd0);
    chk({nm, "_err0"}, 32'(err), 32'd0);
    q.delete();
    mdout = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int          w;
    int          off;
    logic [31:0] pd;
    do_reset("por");
    wait_ready("clear_cycles");

    issue(1'b0, 10'h000, 4'h0, 32'h0);
    issue(1'b0, 10'h31C, 4'h0, 32'h0);
    issue(1'b0, 10'h3FC, 4'h0, 32'h0);

    issue(1'b1, 10'h010, 4'b1111, 32'hDEADBEEF);
    issue(1'b1, 10'h010, 4'b0101, 32'h11223344);
    issue(1'b0, 10'h010, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("merge_dout", dout, 32'hDE22BE44);

    issue(1'b1, 10'h012, 4'hF, 32'hCAFEF00D);
    issue(1'b0, 10'h320, 4'h0, 32'h0);
    issue(1'b0, 10'h010, 4'h0, 32'h0);

    issue(1'b1, 10'h020, 4'hF, 32'h55AA55AA);
    issue(1'b0, 10'h020, 4'h0, 32'h0);
    issue(1'b1, 10'h020, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 10'h020, 4'h0, 32'h0);

    for (int k = 0; k < 400; k++) begin
      w   = int'($urandom_range(0, 219));
      off = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(1'($urandom_range(0, 1)), AW'(w * 4 + off),
            4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

`ifdef RAM_BE_PARITY_EN
    issue(1'b1, 10'h010, 4'hF, 32'h12345678);
    @(posedge clk);
    #1;
    dut.mem[4][16] = ~dut.mem[4][16];
    pd = mdl[4];
    pd[16] = ~pd[16];
    mdout = pd;
    me.err   = 1'b1;
    me.dout  = pd;
    me.lanes = 4'b0100;
    q.push_back(me);
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = 10'h010;
    @(posedge clk);
    #1 valid = 1'b0;
    issue(1'b1, 10'h010, 4'hF, 32'h0);
`else
    pd = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    do_reset("rst_init");
    repeat (100) @(posedge clk);
    #1;
    do_reset("rst_init2");
    wait_ready("reclear_cycles");

    issue(1'b1, 10'h040, 4'hF, 32'hA5A5A5A5);
    issue(1'b0, 10'h040, 4'h0, 32'h0);
    do_reset("rst_op");
    wait_ready("op_reclear_cycles");
    issue(1'b0, 10'h040, 4'h0, 32'h0);

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_be_sp.md
Name: ram_be_sp

Overview:
Parametrised single-port RAM, byte-addressed, with per-byte write strobes.
Uses a valid/ready request handshake and a registered response (resp_valid, dout, err).
After reset, a hardware clear sequence zeroes every word before the first request is accepted.
Serves as the generic local data store for datapath blocks. Width, depth and error checks are configurable.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8, minimum 8.
DEPTH, 256, number of words; need not be a power of 2.
BYTES, DATA_W/8, derived localparam: byte lanes per word.
OFF_W, $clog2(BYTES), derived localparam: byte-offset bits (0 when BYTES=1).
ADDR_W, $clog2(DEPTH)+OFF_W, derived localparam: byte address width.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
valid  input  1  request present
wr_rd  input  1  1=write, 0=read
addr  input  ADDR_W  byte address; low OFF_W bits must be 0
be  input  BYTES  byte write enables, bit i -> din[8i+7:8i]; ignored on reads
din  input  DATA_W  write data
ready  output  1  request accepted when valid && ready
dout  output  DATA_W  read data, held until next read response
resp_valid  output  1  one-cycle response pulse per accepted request
err  output  1  qualified by resp_valid: misaligned or out-of-range access
init_done  output  1  high once the clear sequence has completed

Behaviour:
- Reset values (async, immediate): ready=0, dout=0, resp_valid=0, err=0, init_done=0, state=INIT, clear counter=0.
- FSM has two states, INIT and IDLE.
- INIT: one word per cycle, mem[cnt]<=0, cnt increments 0..DEPTH-1. After writing DEPTH-1, go to IDLE; clearing takes exactly DEPTH cycles after rst deasserts. In INIT: ready=0, requests ignored, no responses.
- IDLE: ready=1 and init_done=1, registered, asserted on the first IDLE cycle. Stays in IDLE until rst.
- Accept = valid && ready. Word index = addr[ADDR_W-1:OFF_W].
- Illegal access: addr[OFF_W-1:0]!=0, or word index >= DEPTH. Memory is untouched, dout is unchanged, and the response has err=1.
- Write: each lane with be[i]=1 updates in the accept cycle. Lanes with be[i]=0 keep their old value. be=0 is legal: no change, normal response.
- Read: mem[index] is registered into dout.
- Timing: resp_valid=1 exactly one cycle after accept, for one cycle. err is valid in the same cycle. Back-to-back accepts give back-to-back responses (throughput 1/cycle).
- Read-after-write to the same address in consecutive cycles returns the new data, since there is a single port and the write has already completed.
- dout changes only on a legal read response; writes and errors hold it.
- Reset mid-INIT restarts the clear from 0. Reset mid-operation drops any pending response, with no resp_valid after reset. Memory contents during reset are don't-care because INIT re-clears them.
- A single request is held from cycle to cycle: the requester drops valid after acceptance, or it is treated as a new request each cycle.

Optional Feature:
Macro RAM_BE_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written with that lane's data; INIT clears it to 0.
  - On a read response, err=1 if any lane's stored parity mismatches its data; dout is still driven.
  - An extra output port, par_err_lanes[BYTES-1:0], is valid with resp_valid.
- Not defined: no parity storage, no extra port, and err reflects address errors only.

Decomposition:
- Package ram_be_pkg holds:
  - state enum typedef {INIT, IDLE};
  - function calc_addr_w(depth, data_w);
  - function even_parity(byte).
- Sub-module ram_be_clear_fsm owns the INIT counter, the state, ready and init_done. It outputs clr_we, clr_addr and state to the top.
- The top holds the memory array, the byte-lane merge, address checks and the response register.

Test Plan:
- Reset then idle, DATA_W=32, DEPTH=256 -> ready=0 for 256 cycles after rst falls, then ready=1 and init_done=1; reads of addr 0x000 and 0x3FC return 0 with err=0.
- Write 0xDEADBEEF at 0x010 with be=4'b1111, then be=4'b0101 with din=0x11223344, then read 0x010 -> dout=0xDE22BE44 one cycle after read accept, resp_valid pulses once per request.
- Misaligned write at 0x012 and, with DEPTH=200, a read at 0x320 -> err=1 on both responses, memory and dout unchanged (verify with a subsequent read of 0x010).
- Back-to-back: write 0x55AA55AA at 0x020 then read 0x020 in the next cycle -> 0x55AA55AA, resp_valid high two consecutive cycles.
- rst asserted at cycle 100 of INIT and again one cycle after a read accept -> outputs zero immediately, no stray resp_valid, clear restarts and takes a full DEPTH cycles.
- With RAM_BE_PARITY_EN: force-flip one stored bit of lane 2 via hierarchical deposit, then read -> err=1, par_err_lanes=4'b0100.
